// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I pipeline: shifter select codes,
// shift funct3 values and the ID/EX register bundle.
`timescale 1ns/1ps
package riscv_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [1:0] SHIFT_SRL  = 2'b00;
    localparam logic [1:0] SHIFT_SLL  = 2'b01;
    localparam logic [1:0] SHIFT_SRA  = 2'b10;
    localparam logic [1:0] SHIFT_ZERO = 2'b11;

    localparam logic [2:0] FUNCT3_SLL = 3'b001;
    localparam logic [2:0] FUNCT3_SR  = 3'b101;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [REG_AW-1:0] rd_addr;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [4:0]        shamt;
        logic [2:0]        funct3;
        logic              funct7b5;
        logic              is_shift;
        logic              use_imm;
        logic              reg_we;
        logic              is_load;
    } id_ex_t;

    function automatic logic [1:0] shift_sel(
        input logic       valid,
        input logic       is_shift,
        input logic [2:0] funct3,
        input logic       funct7b5
    );
        logic       go;
        logic [1:0] sel;
        go  = valid & is_shift;
        sel = SHIFT_ZERO;
        unique case (1'b1)
            go && funct3 == FUNCT3_SLL:              sel = SHIFT_SLL;
            go && funct3 == FUNCT3_SR && !funct7b5:  sel = SHIFT_SRL;
            go && funct3 == FUNCT3_SR && funct7b5:   sel = SHIFT_SRA;
            default:                                 sel = SHIFT_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass: EX/MEM beats MEM/WB, regfile data otherwise;
// x0 is never bypassed.
`timescale 1ns/1ps
module fwd_mux
    import riscv_pkg::*;
#(
    parameter int XLEN = DATA_W,
    parameter int RA_W = REG_AW
) (
    input  logic [RA_W-1:0] idx,
    input  logic [XLEN-1:0] rf_data,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic            exmem_we,
    input  logic [XLEN-1:0] exmem_data,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic            memwb_we,
    input  logic [XLEN-1:0] memwb_data,
    output logic [XLEN-1:0] data
);

    logic exmem_hit;
    logic memwb_hit;

    assign exmem_hit = exmem_we && (exmem_rd != '0) && (exmem_rd == idx);
    assign memwb_hit = memwb_we && (memwb_rd != '0) && (memwb_rd == idx);

    always_comb begin
        data = rf_data;
        unique case (1'b1)
            exmem_hit:              data = exmem_data;
            !exmem_hit && memwb_hit: data = memwb_data;
            default:                data = rf_data;
        endcase
    end

endmodule

// File: rtl/ex_shift_operand_stage.sv
// ID/EX register for the shift datapath: captures decoded shifts,
// bypasses operands, drives the shifter and handles load-use stalls.
`timescale 1ns/1ps
module ex_shift_operand_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = DATA_W,
    parameter int RA_W = REG_AW
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_id_valid,
    input  logic [RA_W-1:0] i_id_rs1_addr,
    input  logic [RA_W-1:0] i_id_rs2_addr,
    input  logic [RA_W-1:0] i_id_rd_addr,
    input  logic [XLEN-1:0] i_id_rs1_data,
    input  logic [XLEN-1:0] i_id_rs2_data,
    input  logic [XLEN-1:0] i_id_imm,
    input  logic [2:0]      i_id_funct3,
    input  logic            i_id_funct7b5,
    input  logic            i_id_is_shift,
    input  logic            i_id_use_imm,
    input  logic            i_id_uses_rs1,
    input  logic            i_id_uses_rs2,
    input  logic            i_id_reg_we,
    input  logic            i_id_is_load,
    input  logic            i_flush,
    input  logic [RA_W-1:0] i_exmem_rd,
    input  logic            i_exmem_we,
    input  logic [XLEN-1:0] i_exmem_data,
    input  logic [RA_W-1:0] i_memwb_rd,
    input  logic            i_memwb_we,
    input  logic [XLEN-1:0] i_memwb_data,
    output logic            o_ex_valid,
    output logic [RA_W-1:0] o_ex_rd_addr,
    output logic            o_ex_reg_we,
    output logic            o_ex_is_load,
    output logic [XLEN-1:0] o_sh_in,
    output logic [4:0]      o_sh_amt,
    output logic [1:0]      o_sh_sel,
    output logic [XLEN-1:0] o_ex_rs2_fwd,
    output logic            o_load_use_stall
);

    id_ex_t          ex_q;
    id_ex_t          ex_d;
    logic            hazard;
    logic            next_valid;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    // Only the shift amount field of the immediate reaches EX.
    logic unused_imm_hi;
    assign unused_imm_hi = ^i_id_imm[XLEN-1:5];

    assign hazard = ex_q.valid && ex_q.is_load &&
                    (ex_q.rd_addr != '0) && i_id_valid &&
                    ((i_id_uses_rs1 && i_id_rs1_addr == ex_q.rd_addr) ||
                     (i_id_uses_rs2 && i_id_rs2_addr == ex_q.rd_addr));

    assign next_valid       = i_id_valid & ~i_flush & ~hazard;
    assign o_load_use_stall = hazard & ~i_flush;

    always_comb begin
        ex_d          = '0;
        ex_d.valid    = next_valid;
        ex_d.rs1_addr = i_id_rs1_addr;
        ex_d.rs2_addr = i_id_rs2_addr;
        ex_d.rd_addr  = i_id_rd_addr;
        ex_d.rs1_data = i_id_rs1_data;
        ex_d.rs2_data = i_id_rs2_data;
        ex_d.shamt    = i_id_imm[4:0];
        ex_d.funct3   = i_id_funct3;
        ex_d.funct7b5 = i_id_funct7b5;
        ex_d.is_shift = i_id_is_shift;
        ex_d.use_imm  = i_id_use_imm;
        ex_d.reg_we   = i_id_reg_we & next_valid;
        ex_d.is_load  = i_id_is_load & next_valid;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
        .idx        (ex_q.rs1_addr),
        .rf_data    (ex_q.rs1_data),
        .exmem_rd   (i_exmem_rd),
        .exmem_we   (i_exmem_we),
        .exmem_data (i_exmem_data),
        .memwb_rd   (i_memwb_rd),
        .memwb_we   (i_memwb_we),
        .memwb_data (i_memwb_data),
        .data       (rs1_fwd)
    );

    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
        .idx        (ex_q.rs2_addr),
        .rf_data    (ex_q.rs2_data),
        .exmem_rd   (i_exmem_rd),
        .exmem_we   (i_exmem_we),
        .exmem_data (i_exmem_data),
        .memwb_rd   (i_memwb_rd),
        .memwb_we   (i_memwb_we),
        .memwb_data (i_memwb_data),
        .data       (rs2_fwd)
    );

    assign o_ex_valid   = ex_q.valid;
    assign o_ex_rd_addr = ex_q.rd_addr;
    assign o_ex_reg_we  = ex_q.valid & ex_q.reg_we;
    assign o_ex_is_load = ex_q.valid & ex_q.is_load;
    assign o_sh_in      = rs1_fwd;
    assign o_sh_amt     = ex_q.use_imm ? ex_q.shamt : rs2_fwd[4:0];
    assign o_sh_sel     = shift_sel(ex_q.valid, ex_q.is_shift,
                                    ex_q.funct3, ex_q.funct7b5);
    assign o_ex_rs2_fwd = rs2_fwd;

endmodule

// File: tb/tb_ex_shift_operand_stage.sv
// Scoreboard bench: driver pushes expected EX outputs from a behavioural
// model, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_ex_shift_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_funct7b5, id_is_shift, id_use_imm;
    logic        id_uses_rs1, id_uses_rs2, id_reg_we, id_is_load, flush;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_d1, id_d2, id_imm;
    logic [2:0]  id_f3;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_we, memwb_we;
    logic [31:0] exmem_data, memwb_data;
    logic        ex_valid, ex_reg_we, ex_is_load, stall;
    logic [4:0]  ex_rd, sh_amt;
    logic [31:0] sh_in, rs2_fwd;
    logic [1:0]  sh_sel;

    always #5 clk = ~clk;

    ex_shift_operand_stage dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_id_valid(id_valid), .i_id_rs1_addr(id_rs1),
        .i_id_rs2_addr(id_rs2), .i_id_rd_addr(id_rd),
        .i_id_rs1_data(id_d1), .i_id_rs2_data(id_d2),
        .i_id_imm(id_imm), .i_id_funct3(id_f3),
        .i_id_funct7b5(id_funct7b5), .i_id_is_shift(id_is_shift),
        .i_id_use_imm(id_use_imm), .i_id_uses_rs1(id_uses_rs1),
        .i_id_uses_rs2(id_uses_rs2), .i_id_reg_we(id_reg_we),
        .i_id_is_load(id_is_load), .i_flush(flush),
        .i_exmem_rd(exmem_rd), .i_exmem_we(exmem_we),
        .i_exmem_data(exmem_data), .i_memwb_rd(memwb_rd),
        .i_memwb_we(memwb_we), .i_memwb_data(memwb_data),
        .o_ex_valid(ex_valid), .o_ex_rd_addr(ex_rd),
        .o_ex_reg_we(ex_reg_we), .o_ex_is_load(ex_is_load),
        .o_sh_in(sh_in), .o_sh_amt(sh_amt), .o_sh_sel(sh_sel),
        .o_ex_rs2_fwd(rs2_fwd), .o_load_use_stall(stall)
    );

    typedef struct {
        bit        valid;
        bit [4:0]  rs1, rs2, rd;
        bit [31:0] d1, d2, imm;
        bit [2:0]  f3;
        bit        b5, is_shift, use_imm, u1, u2, we, ld, flush;
        bit [4:0]  xr, wr;
        bit        xw, ww;
        bit [31:0] xd, wd;
    } stim_t;

    typedef struct {
        bit        valid, we, ld, stall;
        bit [4:0]  rd, amt;
        bit [1:0]  sel;
        bit [31:0] sh_in, rs2f;
    } exp_t;

    exp_t  q[$];
    stim_t cur;
    stim_t ex_m;
    bit    ex_v;
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Value an instruction in EX sees for a source register this cycle.
    function automatic bit [31:0] m_fwd(input bit [4:0] idx,
                                        input bit [31:0] rf,
                                        input stim_t s);
        if (idx != 0 && s.xw && s.xr == idx) return s.xd;
        if (idx != 0 && s.ww && s.wr == idx) return s.wd;
        return rf;
    endfunction

    function automatic bit [1:0] m_sel(input bit v, input stim_t e);
        if (!v || !e.is_shift) return 2'd3;
        if (e.f3 == 3'd1) return 2'd1;
        if (e.f3 == 3'd5) return e.b5 ? 2'd2 : 2'd0;
        return 2'd3;
    endfunction

    function automatic bit m_hazard(input stim_t s);
        return ex_v && ex_m.ld && ex_m.rd != 0 && s.valid &&
               ((s.u1 && s.rs1 == ex_m.rd) || (s.u2 && s.rs2 == ex_m.rd));
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    task automatic apply(input stim_t s);
        id_valid = s.valid; id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
        id_d1 = s.d1; id_d2 = s.d2; id_imm = s.imm; id_f3 = s.f3;
        id_funct7b5 = s.b5; id_is_shift = s.is_shift;
        id_use_imm = s.use_imm; id_uses_rs1 = s.u1; id_uses_rs2 = s.u2;
        id_reg_we = s.we; id_is_load = s.ld; flush = s.flush;
        exmem_rd = s.xr; exmem_we = s.xw; exmem_data = s.xd;
        memwb_rd = s.wr; memwb_we = s.ww; memwb_data = s.wd;
    endtask

    task automatic drive(input stim_t s);
        exp_t e;
        bit [31:0] r2;
        apply(s);
        r2      = m_fwd(ex_m.rs2, ex_m.d2, s);
        e.valid = ex_v;
        e.we    = ex_v & ex_m.we;
        e.ld    = ex_v & ex_m.ld;
        e.rd    = ex_m.rd;
        e.sh_in = m_fwd(ex_m.rs1, ex_m.d1, s);
        e.rs2f  = r2;
        e.amt   = ex_m.use_imm ? ex_m.imm[4:0] : r2[4:0];
        e.sel   = m_sel(ex_v, ex_m);
        e.stall = m_hazard(s) && !s.flush;
        q.push_back(e);
        cur = s;
    endtask

    task automatic tick();
        bit hz;
        @(posedge clk);
        hz   = m_hazard(cur);
        ex_v = cur.valid && !cur.flush && !hz;
        ex_m = cur;
        #1;
    endtask

    function automatic stim_t rnd();
        stim_t s;
        s.valid = ($urandom_range(0, 9) < 8);
        s.rs1 = 5'($urandom_range(0, 3));
        s.rs2 = 5'($urandom_range(0, 3));
        s.rd  = 5'($urandom_range(0, 3));
        s.d1 = $urandom; s.d2 = $urandom; s.imm = $urandom;
        s.f3 = ($urandom_range(0, 1) == 1) ?
               (($urandom_range(0, 1) == 1) ? 3'd1 : 3'd5) :
               3'($urandom_range(0, 7));
        s.b5 = 1'($urandom); s.is_shift = ($urandom_range(0, 3) != 0);
        s.use_imm = 1'($urandom); s.u1 = 1'($urandom);
        s.u2 = 1'($urandom); s.we = 1'($urandom);
        s.ld = ($urandom_range(0, 9) < 3);
        s.flush = ($urandom_range(0, 9) == 0);
        s.xr = 5'($urandom_range(0, 3)); s.xw = 1'($urandom);
        s.xd = $urandom;
        s.wr = 5'($urandom_range(0, 3)); s.ww = 1'($urandom);
        s.wd = $urandom;
        return s;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && q.size() > 0) begin
            e = q.pop_front();
            chk("valid", 32'(ex_valid), 32'(e.valid));
            chk("reg_we", 32'(ex_reg_we), 32'(e.we));
            chk("is_load", 32'(ex_is_load), 32'(e.ld));
            chk("sh_sel", 32'(sh_sel), 32'(e.sel));
            chk("stall", 32'(stall), 32'(e.stall));
            if (e.valid) begin
                chk("rd", 32'(ex_rd), 32'(e.rd));
                chk("sh_in", sh_in, e.sh_in);
                chk("sh_amt", 32'(sh_amt), 32'(e.amt));
                chk("rs2_fwd", rs2_fwd, e.rs2f);
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_valid"}, 32'(ex_valid), 0);
        chk({tag, "_reg_we"}, 32'(ex_reg_we), 0);
        chk({tag, "_is_load"}, 32'(ex_is_load), 0);
        chk({tag, "_rd"}, 32'(ex_rd), 0);
        chk({tag, "_sel"}, 32'(sh_sel), 3);
        chk({tag, "_sh_in"}, sh_in, 0);
        chk({tag, "_amt"}, 32'(sh_amt), 0);
        chk({tag, "_rs2f"}, rs2_fwd, 0);
        chk({tag, "_stall"}, 32'(stall), 0);
    endtask

    initial begin
        stim_t s, sll, lw;
        ex_m = nop(); ex_v = 0; cur = nop();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(rnd());
            @(negedge clk);
            check_reset("rst");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // SRAI x5 by 4
        s = nop(); s.valid = 1; s.rs1 = 5; s.d1 = 32'h8000_0010;
        s.imm = 4; s.f3 = 3'd5; s.b5 = 1; s.is_shift = 1;
        s.use_imm = 1; s.u1 = 1; s.we = 1; s.rd = 9;
        drive(s); tick();
        drive(nop());
        @(negedge clk);
        chk("srai_valid", 32'(ex_valid), 1);
        chk("srai_in", sh_in, 32'h8000_0010);
        chk("srai_amt", 32'(sh_amt), 4);
        chk("srai_sel", 32'(sh_sel), 2);
        tick();

        // Forwarding priority on rs1=x7
        s = nop(); s.valid = 1; s.rs1 = 7; s.d1 = 32'h3333;
        s.f3 = 3'd1; s.is_shift = 1; s.use_imm = 1; s.imm = 1; s.u1 = 1;
        drive(s); tick();
        sll = s;
        s = sll; s.xr = 7; s.xw = 1; s.xd = 32'h1111;
        s.wr = 7; s.ww = 1; s.wd = 32'h2222;
        drive(s);
        @(negedge clk);
        chk("fwd_exmem", sh_in, 32'h1111);
        tick();
        s = sll; s.xr = 0; s.xw = 1; s.xd = 32'h1111;
        s.wr = 0; s.ww = 1; s.wd = 32'h2222;
        drive(s);
        @(negedge clk);
        chk("fwd_x0", sh_in, 32'h3333);
        tick();
        s = nop(); s.xr = 6; s.xw = 1; s.xd = 32'h1111;
        s.wr = 7; s.ww = 1; s.wd = 32'h2222;
        drive(s);
        @(negedge clk);
        chk("fwd_memwb", sh_in, 32'h2222);
        tick();

        // Load-use: lw x3 then SLL using rs2=x3
        lw = nop(); lw.valid = 1; lw.rd = 3; lw.we = 1; lw.ld = 1;
        lw.rs1 = 2; lw.u1 = 1;
        sll = nop(); sll.valid = 1; sll.rs1 = 1; sll.d1 = 1;
        sll.rs2 = 3; sll.d2 = 32'h1f; sll.u1 = 1; sll.u2 = 1;
        sll.is_shift = 1; sll.f3 = 3'd1; sll.we = 1; sll.rd = 4;
        drive(lw); tick();
        drive(sll);
        @(negedge clk);
        chk("lu_stall", 32'(stall), 1);
        tick();
        drive(sll);
        @(negedge clk);
        chk("lu_stall_once", 32'(stall), 0);
        chk("lu_bubble", 32'(ex_valid), 0);
        tick();
        s = nop(); s.wr = 3; s.ww = 1; s.wd = 32'h0000_0007;
        drive(s);
        @(negedge clk);
        chk("lu_recap", 32'(ex_valid), 1);
        chk("lu_amt", 32'(sh_amt), 7);
        chk("lu_sel", 32'(sh_sel), 1);
        tick();

        // Flush wins over hazard
        drive(lw); tick();
        s = sll; s.flush = 1;
        drive(s);
        @(negedge clk);
        chk("fl_stall", 32'(stall), 0);
        tick();
        drive(nop());
        @(negedge clk);
        chk("fl_bubble", 32'(ex_valid), 0);
        tick();

        // Register-sourced amount, then a non-shift
        s = nop(); s.valid = 1; s.rs2 = 6; s.d2 = 32'hFFFF_FFE3;
        s.u2 = 1; s.is_shift = 1; s.f3 = 3'd1;
        drive(s); tick();
        s.is_shift = 0;
        drive(s);
        @(negedge clk);
        chk("reg_amt", 32'(sh_amt), 3);
        chk("reg_sel", 32'(sh_sel), 1);
        tick();
        drive(nop());
        @(negedge clk);
        chk("nonshift_sel", 32'(sh_sel), 3);
        tick();

        for (int i = 0; i < 400; i++) begin
            drive(rnd());
            tick();
        end

        // Asynchronous reset in the middle of a cycle
        drive(s); tick();
        drive(nop());
        #2;
        rst_n = 1'b0;
        q.delete();
        ex_m = nop(); ex_v = 0;
        @(negedge clk);
        check_reset("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        s = nop(); s.valid = 1; s.is_shift = 1; s.f3 = 3'd5;
        s.use_imm = 1; s.imm = 9; s.rd = 2; s.we = 1;
        drive(s); tick();
        drive(nop());
        @(negedge clk);
        chk("post_rst_valid", 32'(ex_valid), 1);
        chk("post_rst_sel", 32'(sh_sel), 0);
        tick();

        for (int i = 0; i < 100; i++) begin
            drive(rnd());
            tick();
        end
        chk("queue_drain", 32'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_shift_operand_stage.md
Name: ex_shift_operand_stage

Overview:
ID/EX pipeline stage for the shift datapath of the pipelined RV32I core. It registers decoded shift instructions from ID and forwards operands from the EX/MEM and MEM/WB stages. It drives the barrel shifter's operand, amount and select inputs during EX. It also detects load-use hazards against the instruction in EX and inserts a bubble, and it kills the captured instruction on an always-taken mispredict flush.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width

Ports:
i_clk  in  1  core clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_id_valid  in  1  ID holds a real instruction
i_id_rs1_addr  in  RA_W  source 1 index
i_id_rs2_addr  in  RA_W  source 2 index
i_id_rd_addr  in  RA_W  destination index
i_id_rs1_data  in  XLEN  regfile read 1
i_id_rs2_data  in  XLEN  regfile read 2
i_id_imm  in  XLEN  decoded immediate
i_id_funct3  in  3  funct3
i_id_funct7b5  in  1  instr[30]
i_id_is_shift  in  1  SLL/SRL/SRA/SLLI/SRLI/SRAI
i_id_use_imm  in  1  shamt from imm[4:0], not rs2
i_id_uses_rs1  in  1  instruction reads rs1
i_id_uses_rs2  in  1  instruction reads rs2
i_id_reg_we  in  1  writes rd
i_id_is_load  in  1  load instruction
i_flush  in  1  branch mispredict, kill ID->EX transfer
i_exmem_rd  in  RA_W  EX/MEM destination
i_exmem_we  in  1  EX/MEM writes rd
i_exmem_data  in  XLEN  EX/MEM result
i_memwb_rd  in  RA_W  MEM/WB destination
i_memwb_we  in  1  MEM/WB writes rd
i_memwb_data  in  XLEN  MEM/WB result
o_ex_valid  out  1  EX holds a real instruction
o_ex_rd_addr  out  RA_W  EX destination
o_ex_reg_we  out  1  EX write enable, gated by valid
o_ex_is_load  out  1  EX is load, gated by valid
o_sh_in  out  XLEN  shifter data input (forwarded rs1)
o_sh_amt  out  5  shifter amount
o_sh_sel  out  2  00 SRL, 01 SLL, 10 SRA, 11 zero output
o_ex_rs2_fwd  out  XLEN  forwarded rs2 (store data / ALU)
o_load_use_stall  out  1  hold PC and IF/ID this cycle

Behaviour:
- Reset (async, i_rst_n=0): all EX registers cleared, o_ex_valid=0, o_ex_reg_we=0, o_ex_is_load=0, o_ex_rd_addr=0, o_sh_sel=11, o_sh_in=0, o_sh_amt=0, o_ex_rs2_fwd=0, o_load_use_stall=0. Reset mid-operation discards the EX instruction with no partial state.
- Capture: on each rising edge the register loads the ID fields, with next valid = i_id_valid & ~i_flush & ~hazard. When next valid=0, a bubble is loaded: the valid, reg_we and is_load bits clear, and the data fields are don't-care.
- Hazard: asserted when ex_valid & ex_is_load & ex_rd!=0 & ((i_id_uses_rs1 & rs1==ex_rd) | (i_id_uses_rs2 & rs2==ex_rd)) & i_id_valid.
- o_load_use_stall = hazard & ~i_flush. It is combinational, and the stall lasts exactly 1 cycle per load-use pair.
- Priority on a simultaneous flush and hazard: flush wins, a bubble is loaded and no stall is raised.
- Forwarding is combinational in EX on the registered rs1/rs2 index and data:
  - EX/MEM hit (we & rd!=0 & rd==idx) has priority over a MEM/WB hit.
  - With no hit, the registered regfile data is used.
  - x0 is never forwarded.
- o_sh_in = forwarded rs1.
- o_sh_amt = registered imm[4:0] when use_imm=1, else forwarded rs2[4:0]. Upper rs2 bits are ignored.
- o_sh_sel decode from the registered funct3/funct7b5 when is_shift & valid:
  - 001 gives 01.
  - 101 with b5=0 gives 00.
  - 101 with b5=1 gives 10.
  - Any other case, including a bubble, gives 11.
- Latency: an instruction in ID at cycle n presents shifter operands during cycle n+1. The shifter result is consumed by the EX/MEM register at the end of n+1.
- The regfile is write-first, so no WB-to-ID bypass is needed here.

Decomposition:
- Shared package riscv_pkg holds:
  - The SHIFT_SRL/SLL/SRA/ZERO 2-bit select constants.
  - The FUNCT3_SLL/FUNCT3_SR constants.
  - A struct id_ex_t holding the registered fields.
- One sub-module, fwd_mux, instantiated twice (rs1, rs2). It takes a register index, regfile data and both forwarding ports, and outputs the selected data.

Test Plan:
- Reset: hold i_rst_n=0 with random inputs -> o_ex_valid=0, o_sh_sel=11, o_load_use_stall=0. Release reset -> first valid capture on the next edge.
- SRAI: capture x5=0x8000_0010 with imm=4, funct3=101, b5=1 -> next cycle o_sh_in=0x8000_0010, o_sh_amt=4, o_sh_sel=10.
- Forward priority: EX rs1=x7 with EX/MEM (rd=7, data 0x1111) and MEM/WB (rd=7, data 0x2222) both writing -> o_sh_in=0x1111. Set rd=0 on both -> regfile data is used.
- Load-use: lw x3 in EX, SLL reading rs2=x3 in ID -> o_load_use_stall=1 for 1 cycle and a bubble is loaded (o_ex_valid=0). The SLL is recaptured the next cycle with o_sh_amt taken from the MEM/WB forward.
- Flush vs hazard: same load-use setup with i_flush=1 -> o_load_use_stall=0 and o_ex_valid=0 next cycle.
- Register-sourced amount: SLL with rs2 data 0xFFFF_FFE3 -> o_sh_amt=3 and o_sh_sel=01. A non-shift instruction -> o_sh_sel=11.
